key_cmd_gen: RTL and testbench

Command generator on the driving side of the LED pattern-mode FSM. Turns three raw, bouncing, active-low push-buttons into the clean single-cycle `in` (advance mode), `start` and `pause` strobes that the pattern FSM consumes. Adds an optional auto-advance timer. Keeps a 2-bit mirror of the FSM's mode (S0–S3, wrapping) for display and debug.

---
 rtl/key_cmd_gen.sv | 166 ++++++++++++++++
 tb/tb_key_cmd_gen.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_gen.sv
// Command generator for the LED pattern FSM: debounces three active-low keys into
// single-cycle in/start/pause strobes, with an optional auto-advance timer and a mode mirror.
module key_cmd_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AUTO_PERIOD     = 50000000,
    parameter int unsigned NUM_MODES       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] key_n,
    output logic       in,
    output logic       start,
    output logic       pause,
    output logic       running,
    output logic       auto_en,
    output logic [1:0] mode
);

    localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TmrW = $clog2(AUTO_PERIOD);

    localparam logic [DebW-1:0] DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TmrW-1:0] TmrLast  = TmrW'(AUTO_PERIOD - 1);
    localparam logic [1:0]      ModeLast = 2'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        StRel,
        StPressChk,
        StHeld,
        StRelChk
    } deb_state_e;

    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    deb_state_e      deb_q [3];
    deb_state_e      deb_d [3];
    logic [DebW-1:0] cnt_q [3];
    logic [DebW-1:0] cnt_d [3];
    logic [2:0]      press_evt;

    logic            in_q, in_d;
    logic            start_q, start_d;
    logic            pause_q, pause_d;
    logic            running_q, running_d;
    logic            auto_q, auto_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [1:0]      mode_q, mode_d;
    logic            tmr_en;
    logic            tmr_tc;

    // Synchronizers and debounce state; synchronizers reset to the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                deb_q[i] <= StRel;
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                deb_q[i] <= deb_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES further agreeing samples.
    always_comb begin
        press_evt = 3'b000;
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = cnt_q[i];
            unique case (deb_q[i])
                StRel: begin
                    if (!sync2_q[i]) begin
                        deb_d[i] = StPressChk;
                        cnt_d[i] = '0;
                    end
                end
                StPressChk: begin
                    if (sync2_q[i]) begin
                        deb_d[i] = StRel;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == DebLast) begin
                        deb_d[i]     = StHeld;
                        cnt_d[i]     = '0;
                        press_evt[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                StHeld: begin
                    if (sync2_q[i]) begin
                        deb_d[i] = StRelChk;
                        cnt_d[i] = '0;
                    end
                end
                StRelChk: begin
                    if (!sync2_q[i]) begin
                        deb_d[i] = StHeld;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == DebLast) begin
                        deb_d[i] = StRel;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    deb_d[i] = StRel;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Manual next and auto terminal count merge into one strobe; either restarts the timer.
    always_comb begin
        tmr_en    = running_q && auto_q;
        tmr_tc    = tmr_en && (tmr_q == TmrLast);
        in_d      = press_evt[0] | tmr_tc;
        start_d   = press_evt[1] & ~running_q;
        pause_d   = press_evt[1] & running_q;
        running_d = running_q ^ press_evt[1];
        auto_d    = auto_q ^ press_evt[2];
        tmr_d     = tmr_q + 1'b1;
        if (!tmr_en || in_d) begin
            tmr_d = '0;
        end
        mode_d = mode_q;
        if (in_q) begin
            mode_d = (mode_q == ModeLast) ? 2'd0 : mode_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q      <= 1'b0;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            running_q <= 1'b0;
            auto_q    <= 1'b0;
            tmr_q     <= '0;
            mode_q    <= 2'd0;
        end else begin
            in_q      <= in_d;
            start_q   <= start_d;
            pause_q   <= pause_d;
            running_q <= running_d;
            auto_q    <= auto_d;
            tmr_q     <= tmr_d;
            mode_q    <= mode_d;
        end
    end

    assign in      = in_q;
    assign start   = start_q;
    assign pause   = pause_q;
    assign running = running_q;
    assign auto_en = auto_q;
    assign mode    = mode_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Scoreboard bench for key_cmd_gen: a cycle-level reference model predicts every strobe,
// a negedge monitor pops and compares; directed phases follow the test plan, then random keys.
module tb_key_cmd_gen;

    localparam int unsigned D  = 4;
    localparam int unsigned P  = 10;
    localparam int unsigned NM = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] key_n;
    logic       in, start, pause, running, auto_en;
    logic [1:0] mode;

    always #5 clk = ~clk;

    key_cmd_gen #(
        .DEBOUNCE_CYCLES(D),
        .AUTO_PERIOD    (P),
        .NUM_MODES      (NM)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .in     (in),
        .start  (start),
        .pause  (pause),
        .running(running),
        .auto_en(auto_en),
        .mode   (mode)
    );

    typedef struct packed {
        int         cyc;
        logic       s_in;
        logic       s_start;
        logic       s_pause;
        logic       s_run;
        logic       s_auto;
        logic [1:0] s_mode;
    } exp_t;

    exp_t sb[$];
    int   in_log[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_in_cyc = -1;
    int   last_start_cyc = -1;
    int   last_pause_cyc = -1;

    // Reference model: a key is accepted as changed after D+1 consecutive disagreeing
    // synchronized samples; synchronized level is the raw key two edges late.
    logic [2:0] m_s1 = 3'b111;
    logic [2:0] m_s2 = 3'b111;
    logic [2:0] m_held = 3'b000;
    int         run_len[3];
    logic       m_run = 1'b0;
    logic       m_auto = 1'b0;
    logic       m_in = 1'b0;
    int         elapsed = 0;
    int         m_mode = 0;

    always @(posedge clk) begin : model
        logic [2:0] ev;
        logic       en, tc, nx, st, ps;
        exp_t       e;
        cyc++;
        if (reset) begin
            m_s1 = 3'b111;
            m_s2 = 3'b111;
            m_held = 3'b000;
            for (int i = 0; i < 3; i++) run_len[i] = 0;
            m_run = 1'b0;
            m_auto = 1'b0;
            m_in = 1'b0;
            elapsed = 0;
            m_mode = 0;
        end else begin
            ev = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if ((!m_s2[i]) != m_held[i]) begin
                    run_len[i]++;
                    if (run_len[i] == D + 1) begin
                        m_held[i] = ~m_held[i];
                        run_len[i] = 0;
                        if (m_held[i]) ev[i] = 1'b1;
                    end
                end else begin
                    run_len[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
            if (m_in) m_mode = (m_mode + 1) % NM;
            en = m_run && m_auto;
            tc = en && (elapsed == P - 1);
            nx = ev[0] || tc;
            elapsed = (!en || nx) ? 0 : elapsed + 1;
            st = ev[1] && !m_run;
            ps = ev[1] && m_run;
            if (ev[1]) m_run = !m_run;
            if (ev[2]) m_auto = !m_auto;
            m_in = nx;
            if (nx || st || ps) begin
                e = '{cyc, nx, st, ps, m_run, m_auto, 2'(m_mode)};
                sb.push_back(e);
            end
        end
    end

    // Monitor: pops one prediction for every strobe the DUT presents.
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t a;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_strobe: nothing at cycle %0d, required in=%b start=%b pause=%b",
                     e.cyc, e.s_in, e.s_start, e.s_pause);
        end
        if (in || start || pause) begin
            if (in) begin
                in_log.push_back(cyc);
                last_in_cyc = cyc;
            end
            if (start) last_start_cyc = cyc;
            if (pause) last_pause_cyc = cyc;
            a = '{cyc, in, start, pause, running, auto_en, mode};
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: cycle %0d in=%b start=%b pause=%b, required none",
                         cyc, in, start, pause);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_err++;
                    $display({"FAIL strobe: got cyc=%0d in=%b start=%b pause=%b run=%b auto=%b ",
                              "mode=%0d, required cyc=%0d in=%b start=%b pause=%b run=%b auto=%b ",
                              "mode=%0d"},
                             a.cyc, a.s_in, a.s_start, a.s_pause, a.s_run, a.s_auto, a.s_mode,
                             e.cyc, e.s_in, e.s_start, e.s_pause, e.s_run, e.s_auto, e.s_mode);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int count_in(input int lo, input int hi);
        int n = 0;
        foreach (in_log[i]) if (in_log[i] > lo && in_log[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_in_after(input int t);
        foreach (in_log[i]) if (in_log[i] > t) return in_log[i];
        return -1;
    endfunction

    initial begin
        int low_cyc, n0, c0, c1, c2, e1, e2, rc;
        int hold[3];
        reset = 1'b1;
        key_n = 3'b111;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(100);
        check("idle_in", int'(in), 0);
        check("idle_start", int'(start), 0);
        check("idle_pause", int'(pause), 0);
        check("idle_running", int'(running), 0);
        check("idle_auto_en", int'(auto_en), 0);
        check("idle_mode", int'(mode), 0);

        // Bounce then a clean press, four times: mode wraps back to 0.
        n0 = in_log.size();
        for (int rep = 0; rep < 4; rep++) begin
            key_n[0] = 1'b0;
            wait_cycles(3);
            key_n[0] = 1'b1;
            wait_cycles(2);
            low_cyc = cyc;
            key_n[0] = 1'b0;
            wait_cycles(20);
            key_n[0] = 1'b1;
            wait_cycles(20);
            check("next_latency", last_in_cyc - low_cyc, D + 3);
            check("next_pulses", in_log.size() - n0, rep + 1);
            check("next_mode", int'(mode), (rep + 1) % NM);
        end

        // Run/pause toggle.
        for (int r = 0; r < 2; r++) begin
            c0 = cyc;
            key_n[1] = 1'b0;
            wait_cycles(20);
            key_n[1] = 1'b1;
            wait_cycles(20);
            check("run_level", int'(running), (r == 0) ? 1 : 0);
            check("run_strobe_cycle", (r == 0) ? last_start_cyc : last_pause_cyc, c0 + D + 3);
        end

        // Auto-advance while running.
        key_n[2] = 1'b0;
        wait_cycles(20);
        key_n[2] = 1'b1;
        wait_cycles(20);
        check("auto_level", int'(auto_en), 1);
        c0 = cyc;
        e1 = c0 + D + 3;
        key_n[1] = 1'b0;
        wait_cycles(20);
        key_n[1] = 1'b1;
        wait_cycles(23);
        check("auto_start_cycle", last_start_cyc, e1);
        check("auto_count", count_in(e1, e1 + 35), 3);
        check("auto_first", first_in_after(e1), e1 + P);
        check("auto_mode", int'(mode), 3);

        // Pause halts auto strobes.
        c1 = cyc;
        key_n[1] = 1'b0;
        wait_cycles(20);
        key_n[1] = 1'b1;
        wait_cycles(30);
        check("pause_cycle", last_pause_cyc, c1 + D + 3);
        check("pause_level", int'(running), 0);
        check("pause_no_in", count_in(last_pause_cyc, cyc), 0);

        // Manual next lands on the auto terminal count: one strobe, timer restarts.
        c2 = cyc;
        e2 = c2 + D + 3;
        key_n[1] = 1'b0;
        wait_cycles(e2 + 2 * P - (D + 3) - cyc);
        key_n = 3'b110;
        wait_cycles(20);
        key_n = 3'b111;
        wait_cycles(20);
        check("coinc_start_cycle", last_start_cyc, e2);
        check("coinc_count", count_in(e2, e2 + 35), 3);
        check("coinc_merged", first_in_after(e2 + P), e2 + 2 * P);
        check("coinc_next_auto", first_in_after(e2 + 2 * P), e2 + 3 * P);

        // Reset mid press-check discards progress.
        key_n[0] = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        rc = cyc;
        wait_cycles(20);
        key_n[0] = 1'b1;
        wait_cycles(20);
        check("rst_latency", last_in_cyc - rc, D + 3);
        check("rst_pulses", count_in(rc, cyc), 1);
        check("rst_mode", int'(mode), 1);
        check("rst_running", int'(running), 0);

        // Random key traffic with occasional resets.
        for (int i = 0; i < 3; i++) hold[i] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    key_n[i] = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 12);
                end else begin
                    hold[i]--;
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        key_n = 3'b111;
        wait_cycles(40);
        check("drain_queue", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
